// File: rtl/pingpong_ctrl.sv
// Ping-pong game controller: ball position/direction, step timing, hit/miss/fault judgement, scoring.
// Optional point tone: define PP_BUZZER_EN to enable the buzzer tone generator (default build ties buzzer to 0).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | after reset, waiting for start_stop
//   S_SERVE  | ball parked at the server's end, waiting for the server's press
//   S_MOVE_L | ball travelling toward led[4] (player A receives)
//   S_MOVE_R | ball travelling toward led[0] (player B receives)
//   S_POINT  | point pause after a miss or fault
//   S_OVER   | a player reached WIN_SCORE, left only by reset
module pingpong_ctrl #(
    parameter int STEP_CYCLES = 47_000_000,
    parameter int BUZZ_CYCLES = 12_500_000,
    parameter int TONE_DIV    = 25_000,
    parameter int WIN_SCORE   = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       btn_a,
    input  logic       btn_b,
    output logic [4:0] led,
    output logic [1:0] state,
    output logic       step,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic       buzzer,
    output logic       game_over
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_MOVE_L, S_MOVE_R, S_POINT, S_OVER
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [2:0]    sync_a, sync_b;
    logic [2:0]    pos;
    logic          server_a;
    logic [SW-1:0] step_cnt;
    logic [BW-1:0] buzz_cnt;
    logic          tone_on;

    logic       ev_a, ev_b, moving, rx_is_a, rx_ev, at_end, step_due;
    logic [2:0] rx_end;
    logic       serve_ev, hit, rally_end, adv, buzz_done, win_reached;

    // [0],[1] synchroniser stages, [2] previous synchronised level for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], btn_a};
            sync_b <= {sync_b[1:0], btn_b};
        end
    end

    assign ev_a = sync_a[1] & ~sync_a[2];
    assign ev_b = sync_b[1] & ~sync_b[2];

    assign moving      = (fsm_q == S_MOVE_L) || (fsm_q == S_MOVE_R);
    assign rx_is_a     = (fsm_q == S_MOVE_L);
    assign rx_ev       = rx_is_a ? ev_a : ev_b;
    assign rx_end      = rx_is_a ? 3'd4 : 3'd0;
    assign at_end      = (pos == rx_end);
    assign step_due    = (step_cnt == STEP_LAST);
    assign serve_ev    = start_stop && (fsm_q == S_SERVE) && (server_a ? ev_a : ev_b);
    assign hit         = start_stop && moving && rx_ev && at_end;
    // a receiver press away from its end is a fault, a step at its end is a miss; the sender wins both
    assign rally_end   = start_stop && moving && ((rx_ev && !at_end) || (!rx_ev && at_end && step_due));
    assign adv         = start_stop && moving && !rx_ev && !at_end && step_due;
    assign buzz_done   = start_stop && (fsm_q == S_POINT) && (buzz_cnt == BUZZ_LAST);
    assign win_reached = (score_a == 4'(WIN_SCORE)) || (score_b == 4'(WIN_SCORE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:   if (start_stop) fsm_d = S_SERVE;
            S_SERVE:  if (serve_ev) fsm_d = server_a ? S_MOVE_R : S_MOVE_L;
            S_MOVE_L: begin
                if (hit)            fsm_d = S_MOVE_R;
                else if (rally_end) fsm_d = S_POINT;
            end
            S_MOVE_R: begin
                if (hit)            fsm_d = S_MOVE_L;
                else if (rally_end) fsm_d = S_POINT;
            end
            S_POINT:  if (buzz_done) fsm_d = win_reached ? S_OVER : S_SERVE;
            S_OVER:   fsm_d = S_OVER;
            default:  fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos      <= 3'd4;
            server_a <= 1'b1;
            step_cnt <= '0;
            buzz_cnt <= '0;
            score_a  <= '0;
            score_b  <= '0;
        end else if (start_stop) begin
            if (serve_ev || hit || rally_end || adv) step_cnt <= '0;
            else if (moving)                         step_cnt <= step_cnt + 1'b1;

            // on a lost rally the receiver serves next, so park the ball at its end
            if (adv)            pos <= rx_is_a ? pos + 3'd1 : pos - 3'd1;
            else if (rally_end) pos <= rx_end;

            if (rally_end) begin
                server_a <= rx_is_a;
                if (rx_is_a) score_b <= score_b + 4'd1;
                else         score_a <= score_a + 4'd1;
            end

            if (rally_end)               buzz_cnt <= '0;
            else if (fsm_q == S_POINT)   buzz_cnt <= buzz_done ? '0 : buzz_cnt + 1'b1;
        end
    end

`ifdef PP_BUZZER_EN
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    logic [TW-1:0] tone_cnt;
    logic          tone_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (start_stop) begin
            if (rally_end) begin
                tone_cnt <= '0;
                tone_q   <= 1'b1;
            end else if (fsm_q == S_POINT) begin
                if (tone_cnt == TONE_LAST) begin
                    tone_cnt <= '0;
                    tone_q   <= ~tone_q;
                end else begin
                    tone_cnt <= tone_cnt + 1'b1;
                end
            end
        end
    end

    assign tone_on = tone_q;
`else
    logic unused_tone_div;
    assign unused_tone_div = ^TONE_DIV;
    assign tone_on         = 1'b0;
`endif

    always_comb begin
        led       = '0;
        state     = 2'd0;
        step      = 1'b0;
        buzzer    = 1'b0;
        game_over = 1'b0;
        case (fsm_q)
            S_SERVE:  led = 5'b00001 << pos;
            S_MOVE_L: begin
                led   = 5'b00001 << pos;
                state = 2'd1;
                step  = adv;
            end
            S_MOVE_R: begin
                led   = 5'b00001 << pos;
                state = 2'd2;
                step  = adv;
            end
            S_POINT:  buzzer = start_stop & tone_on;
            S_OVER:   game_over = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Self-checking bench for pingpong_ctrl: scoreboard of expected display/score tuples plus timing checks.
module tb_pingpong_ctrl;

    localparam int STEP = 4;
    localparam int BUZZ = 8;
    localparam int TONE = 2;
    localparam int WIN  = 3;

    logic       clk, reset, start_stop, btn_a, btn_b;
    logic [4:0] led;
    logic [1:0] state;
    logic       step;
    logic [3:0] score_a, score_b;
    logic       buzzer, game_over;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] last_obs;
    logic [15:0] obs;

    assign obs = {game_over, led, state, score_a, score_b};

    pingpong_ctrl #(
        .STEP_CYCLES(STEP),
        .BUZZ_CYCLES(BUZZ),
        .TONE_DIV   (TONE),
        .WIN_SCORE  (WIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .led       (led),
        .state     (state),
        .step      (step),
        .score_a   (score_a),
        .score_b   (score_b),
        .buzzer    (buzzer),
        .game_over (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] tup(input logic g, input logic [4:0] l, input logic [1:0] s,
                                        input logic [3:0] a, input logic [3:0] b);
        return {g, l, s, a, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic a, input logic b);
        btn_a = a;
        btn_b = b;
        tick(1);
        btn_a = 1'b0;
        btn_b = 1'b0;
    endtask

    task automatic wait_step(input int budget, output int n);
        n = 0;
        while (step !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    // each step must come STEP-1 cycles after the previous advance (or after a cleared counter)
    task automatic run_steps(input int k, input string tag);
        int n;
        for (int i = 0; i < k; i++) begin
            wait_step(20, n);
            check_val(tag, n, STEP - 1);
            tick(1);
        end
    endtask

    task automatic buzz_window();
        logic exp;
        for (int i = 0; i < BUZZ; i++) begin
`ifdef PP_BUZZER_EN
            exp = ((i / TONE) % 2) == 0;
`else
            exp = 1'b0;
`endif
            check_val("buzz_pattern", buzzer, exp);
            tick(1);
        end
    endtask

    // scoreboard: every change of the observed tuple must match the next expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && obs !== last_obs) begin
                check_val("sb_avail", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) check_val("sb_obs", obs, sb_q.pop_front());
                last_obs = obs;
            end
        end
    end

    initial begin
        int  n;
        logic saw;
        reset = 1'b0; start_stop = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        tick(2);
        check_val("rst_led", led, 0);
        check_val("rst_state", state, 0);
        check_val("rst_step", step, 0);
        check_val("rst_score_a", score_a, 0);
        check_val("rst_score_b", score_b, 0);
        check_val("rst_buzzer", buzzer, 0);
        check_val("rst_game_over", game_over, 0);
        reset = 1'b1;
        tick(3);
        check_val("idle_hold_led", led, 0);
        last_obs = obs;
        mon_en   = 1'b1;

        // serve by A and travel to B's end
        sb_q.push_back(tup(0, 5'b10000, 0, 0, 0));
        start_stop = 1'b1;
        tick(1);
        check_val("serve_led", led, 5'b10000);
        check_val("serve_state", state, 0);
        sb_q.push_back(tup(0, 5'b10000, 2, 0, 0));
        sb_q.push_back(tup(0, 5'b01000, 2, 0, 0));
        sb_q.push_back(tup(0, 5'b00100, 2, 0, 0));
        sb_q.push_back(tup(0, 5'b00010, 2, 0, 0));
        sb_q.push_back(tup(0, 5'b00001, 2, 0, 0));
        press(1, 0);
        tick(1);
        check_val("sync_latency", state, 0);
        tick(1);
        check_val("serve_go", state, 2);
        run_steps(4, "step_gap_serve");
        check_val("reach_b_end", led, 5'b00001);

        // B returns at its end
        sb_q.push_back(tup(0, 5'b00001, 1, 0, 0));
        sb_q.push_back(tup(0, 5'b00010, 1, 0, 0));
        press(0, 1);
        tick(2);
        check_val("return_b_state", state, 1);
        run_steps(1, "step_gap_return");
        check_val("return_b_led", led, 5'b00010);

        // A misses at its end
        sb_q.push_back(tup(0, 5'b00100, 1, 0, 0));
        sb_q.push_back(tup(0, 5'b01000, 1, 0, 0));
        sb_q.push_back(tup(0, 5'b10000, 1, 0, 0));
        sb_q.push_back(tup(0, 5'b00000, 0, 0, 1));
        sb_q.push_back(tup(0, 5'b10000, 0, 0, 1));
        run_steps(3, "step_gap_to_a");
        tick(4);
        check_val("miss_a_score_b", score_b, 1);
        check_val("miss_a_led", led, 0);
        buzz_window();
        check_val("serve_a_again", led, 5'b10000);
        check_val("serve_buzz_off", buzzer, 0);

        // A serves, B misses, B serves next
        sb_q.push_back(tup(0, 5'b10000, 2, 0, 1));
        sb_q.push_back(tup(0, 5'b01000, 2, 0, 1));
        sb_q.push_back(tup(0, 5'b00100, 2, 0, 1));
        sb_q.push_back(tup(0, 5'b00010, 2, 0, 1));
        sb_q.push_back(tup(0, 5'b00001, 2, 0, 1));
        sb_q.push_back(tup(0, 5'b00000, 0, 1, 1));
        sb_q.push_back(tup(0, 5'b00001, 0, 1, 1));
        press(1, 0);
        tick(2);
        check_val("serve_a2_state", state, 2);
        run_steps(4, "step_gap_a2");
        tick(4);
        check_val("miss_b_score_a", score_a, 1);
        tick(8);
        check_val("serve_by_b", led, 5'b00001);

        // B serves; held sender button ignored; A faults mid-court
        sb_q.push_back(tup(0, 5'b00001, 1, 1, 1));
        sb_q.push_back(tup(0, 5'b00010, 1, 1, 1));
        sb_q.push_back(tup(0, 5'b00100, 1, 1, 1));
        sb_q.push_back(tup(0, 5'b00000, 0, 1, 2));
        sb_q.push_back(tup(0, 5'b10000, 0, 1, 2));
        press(0, 1);
        tick(2);
        check_val("serve_b_state", state, 1);
        btn_b = 1'b1;
        run_steps(2, "step_gap_sender_held");
        btn_b = 1'b0;
        press(1, 0);
        tick(2);
        check_val("fault_a_score_b", score_b, 2);
        check_val("fault_a_state", state, 0);
        tick(8);
        check_val("serve_a3", led, 5'b10000);

        // A serves; sender press ignored; simultaneous presses -> receiver B faults
        sb_q.push_back(tup(0, 5'b10000, 2, 1, 2));
        sb_q.push_back(tup(0, 5'b01000, 2, 1, 2));
        sb_q.push_back(tup(0, 5'b00100, 2, 1, 2));
        sb_q.push_back(tup(0, 5'b00000, 0, 2, 2));
        sb_q.push_back(tup(0, 5'b00001, 0, 2, 2));
        press(1, 0);
        tick(2);
        check_val("serve_a3_state", state, 2);
        btn_a = 1'b1;
        run_steps(1, "step_gap_sender_a");
        btn_a = 1'b0;
        run_steps(1, "step_gap_sender_a2");
        press(1, 1);
        tick(2);
        check_val("fault_b_score_a", score_a, 2);
        check_val("fault_b_score_b", score_b, 2);
        tick(8);
        check_val("serve_b2", led, 5'b00001);

        // B serves, pause mid-move, A returns, B misses -> game over
        sb_q.push_back(tup(0, 5'b00001, 1, 2, 2));
        sb_q.push_back(tup(0, 5'b00010, 1, 2, 2));
        sb_q.push_back(tup(0, 5'b00100, 1, 2, 2));
        sb_q.push_back(tup(0, 5'b01000, 1, 2, 2));
        sb_q.push_back(tup(0, 5'b10000, 1, 2, 2));
        sb_q.push_back(tup(0, 5'b10000, 2, 2, 2));
        sb_q.push_back(tup(0, 5'b01000, 2, 2, 2));
        sb_q.push_back(tup(0, 5'b00100, 2, 2, 2));
        sb_q.push_back(tup(0, 5'b00010, 2, 2, 2));
        sb_q.push_back(tup(0, 5'b00001, 2, 2, 2));
        sb_q.push_back(tup(0, 5'b00000, 0, 3, 2));
        sb_q.push_back(tup(1, 5'b00000, 0, 3, 2));
        press(0, 1);
        tick(2);
        check_val("serve_b2_state", state, 1);
        run_steps(1, "step_gap_pre_pause");
        tick(2);
        start_stop = 1'b0;
        btn_a      = 1'b1;
        saw        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (step !== 1'b0) saw = 1'b1;
            if (i == 2) btn_a = 1'b0;
        end
        check_val("pause_step", saw, 0);
        check_val("pause_led", led, 5'b00010);
        check_val("pause_state", state, 1);
        check_val("pause_score_b", score_b, 2);
        start_stop = 1'b1;
        wait_step(20, n);
        check_val("resume_gap", n, 1);
        tick(1);
        check_val("resume_led", led, 5'b00100);
        run_steps(2, "step_gap_to_a2");
        press(1, 0);
        tick(2);
        check_val("return_a_state", state, 2);
        check_val("return_a_led", led, 5'b10000);
        run_steps(4, "step_gap_final");
        tick(4);
        check_val("final_score_a", score_a, WIN);
        check_val("point_not_over", game_over, 0);
        tick(8);
        check_val("game_over", game_over, 1);
        check_val("over_led", led, 0);
        press(1, 1);
        tick(5);
        check_val("over_state", state, 0);
        check_val("over_hold", game_over, 1);
        mon_en = 1'b0;
        check_val("sb_drained", sb_q.size(), 0);

        // asynchronous reset while in OVER, between clock edges
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_score_a", score_a, 0);
        check_val("arst_game_over", game_over, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        press(1, 0);
        tick(2);
        check_val("run2_state", state, 2);
        run_steps(1, "step_gap_run2");
        tick(1);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_mid_led", led, 0);
        check_val("arst_mid_state", state, 0);
        check_val("arst_mid_step", step, 0);
        check_val("arst_mid_buzzer", buzzer, 0);
        check_val("arst_mid_score_b", score_b, 0);
        tick(1);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
